multicycle_cpu: RTL and testbench
=================================

MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, the memory address width; mem_addr = low ADDR_WIDTH bits of the byte address.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port mem_req  output  1  memory transaction request.
REQ-006 SHALL have port mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-007 SHALL have port mem_addr  output  ADDR_WIDTH  byte address.
REQ-008 SHALL have port mem_wdata  output  32  store data.
REQ-009 SHALL have port mem_rdata  input  32  read data; sampled on the edge where mem_ready=1.
REQ-010 SHALL have port mem_ready  input  1  transaction complete; ignored while mem_req=0.
REQ-011 SHALL have port pc  output  32  current program counter.
REQ-012 SHALL have port retire  output  1  one-cycle pulse per completed instruction.
REQ-013 SHALL have port halted  output  1  core stopped in TRAP.
REQ-014 SHALL have port state  output  3  debug state code: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.

Function
REQ-015 SHALL implement opcodes R-type 0x00 (funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08), J 0x02, JAL 0x03, BNE 0x05, XORI 0x0E, LW 0x23 and SW 0x2B; any other opcode or funct SHALL be illegal.
REQ-016 SHALL contain a 32x32 register file with 2 read ports and 1 write port; r0 SHALL read 0 and ignore writes.
REQ-017 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ready, latch IR and set pc<=pc+4, then go to DECODE.
REQ-018 DECODE: latch A=reg[Rs] and B=reg[Rt]; go to TRAP if illegal, else to EXEC.
REQ-019 EXEC, R-type ADD/SUB/SLT and XORI: compute the result into ALUOut, then go to WB.
REQ-020 EXEC, LW/SW: ALUOut = A + sign-extended imm; if ALUOut[1:0] != 0 go to TRAP, else go to MEM.
REQ-021 EXEC, BNE: if A != B, pc <= pc + (sext(imm) << 2), using the already-incremented pc; then go to FETCH and pulse retire.
REQ-022 EXEC, J: pc <= {pc[31:28], target, 2'b00}; JAL additionally writes the incremented pc into r31; JR: pc <= A; all three go to FETCH and pulse retire.
REQ-023 MEM: mem_req=1, mem_addr=ALUOut, mem_we=1 and mem_wdata=B for SW; on mem_ready, LW latches mem_rdata and goes to WB, SW goes to FETCH and pulses retire.
REQ-024 WB: write Rd (R-type) or Rt (XORI, LW), then go to FETCH and pulse retire.
REQ-025 While mem_req=1, mem_addr, mem_we and mem_wdata SHALL remain stable until the edge where mem_ready=1; wait states are unbounded.
REQ-026 mem_ready high in the first request cycle SHALL complete that transaction (zero-wait); mem_req SHALL be 0 in DECODE, EXEC, WB and TRAP.
REQ-027 Arithmetic: ADD/SUB wrap mod 2^32 with no overflow trap; SLT is a signed compare giving 1 or 0; XORI zero-extends imm; BNE and LW/SW sign-extend imm.
REQ-028 Latency with zero-wait memory SHALL be: BNE/J/JAL/JR 3 cycles, ADD/SUB/SLT/XORI/SW 4 cycles, LW 5 cycles; each wait cycle adds 1.
REQ-029 TRAP: halted=1, retire=0, pc frozen at the address following the faulting instruction; the core SHALL stay in TRAP until reset.
REQ-030 Reads of a register written by the previous instruction SHALL return the new value, because WB completes before the next DECODE.

Reset
REQ-031 reset_n=0 SHALL immediately force: pc=RESET_PC, state=FETCH, all registers 0, retire=0, halted=0, mem_req=0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction with no register or pc update; the first request after reset release SHALL be a fetch from RESET_PC.

Verification
REQ-033 Sequence XORI r1,r0,5 then ADD r2,r1,r1, zero-wait memory -> r2=10, retire pulses at cycles 4 and 8, pc=8.
REQ-034 SW r2,0x10(r0) then LW r3,0x10(r0) with mem_ready delayed 3 cycles per access -> stored word 10, r3=10, LW takes 8 cycles.
REQ-035 BNE r1,r0,-1 with r1=5 -> pc returns to the BNE address repeatedly; with r1=0 -> pc=addr+4.
REQ-036 JAL at 0x40 with target 0x100 -> r31=0x44, pc=0x400; following JR r31 -> pc=0x44.
REQ-037 Opcode 0x3F, and LW with address 0x13 -> halted=1, state=7, mem_req stays 0, no register changes.
REQ-038 reset_n pulsed low during a FETCH wait state -> mem_req drops in the same cycle; after release the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/multicycle_cpu.sv
// Multicycle MIPS-subset core: one shared memory port, FETCH/DECODE/EXEC/MEM/WB sequencing.
// The core halts in TRAP on an illegal instruction or a misaligned load/store address.
module multicycle_cpu #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic [31:0]           pc,
    output logic                  retire,
    output logic                  halted,
    output logic [2:0]            state
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    state_t      cur_state, next_state;
    logic [31:0] ir, a_reg, b_reg, alu_out, mdr;
    logic [31:0] regs [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [25:0] target;
    logic [31:0] sext_imm, zext_imm;

    logic        legal;
    logic        pc_we, ir_we, ab_we, alu_we, mdr_we, rf_we, req;
    logic [31:0] pc_next, alu_next, rf_wdata, addr_full;
    logic [4:0]  rf_waddr;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign target   = ir[25:0];
    assign sext_imm = {{16{ir[15]}}, ir[15:0]};
    assign zext_imm = {16'h0000, ir[15:0]};

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE: legal = (funct == FN_ADD) || (funct == FN_SUB) ||
                              (funct == FN_SLT) || (funct == FN_JR);
            OP_J, OP_JAL, OP_BNE, OP_XORI, OP_LW, OP_SW: legal = 1'b1;
            default:  legal = 1'b0;
        endcase
    end

    always_comb begin
        next_state = cur_state;
        req        = 1'b0;
        mem_we     = 1'b0;
        addr_full  = pc;
        pc_we      = 1'b0;
        pc_next    = pc;
        ir_we      = 1'b0;
        ab_we      = 1'b0;
        alu_we     = 1'b0;
        alu_next   = alu_out;
        mdr_we     = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = rt;
        rf_wdata   = alu_out;
        retire     = 1'b0;

        case (cur_state)
            S_FETCH: begin
                req = 1'b1;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    pc_next    = pc + 32'd4;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                ab_we      = 1'b1;
                next_state = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                next_state = S_TRAP;
                case (opcode)
                    OP_RTYPE: begin
                        alu_we     = 1'b1;
                        next_state = S_WB;
                        case (funct)
                            FN_ADD:  alu_next = a_reg + b_reg;
                            FN_SUB:  alu_next = a_reg - b_reg;
                            FN_SLT:  alu_next = {31'd0, $signed(a_reg) < $signed(b_reg)};
                            FN_JR: begin
                                alu_we     = 1'b0;
                                pc_we      = 1'b1;
                                pc_next    = a_reg;
                                retire     = 1'b1;
                                next_state = S_FETCH;
                            end
                            default: begin
                                alu_we     = 1'b0;
                                next_state = S_TRAP;
                            end
                        endcase
                    end
                    OP_XORI: begin
                        alu_we     = 1'b1;
                        alu_next   = a_reg ^ zext_imm;
                        next_state = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_we     = 1'b1;
                        alu_next   = a_reg + sext_imm;
                        next_state = (alu_next[1:0] != 2'b00) ? S_TRAP : S_MEM;
                    end
                    // pc already points past the branch, so the offset is relative to pc+4
                    OP_BNE: begin
                        if (a_reg != b_reg) begin
                            pc_we   = 1'b1;
                            pc_next = pc + {sext_imm[29:0], 2'b00};
                        end
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end
                    OP_J, OP_JAL: begin
                        pc_we      = 1'b1;
                        pc_next    = {pc[31:28], target, 2'b00};
                        rf_we      = (opcode == OP_JAL);
                        rf_waddr   = 5'd31;
                        rf_wdata   = pc;
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end
                    default: next_state = S_TRAP;
                endcase
            end
            S_MEM: begin
                req       = 1'b1;
                mem_we    = (opcode == OP_SW);
                addr_full = alu_out;
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        mdr_we     = 1'b1;
                        next_state = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                rf_waddr   = (opcode == OP_RTYPE) ? rd : rt;
                rf_wdata   = (opcode == OP_LW) ? mdr : alu_out;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_TRAP;
        endcase
    end

    // Request is masked by reset so an in-flight transaction is dropped immediately
    assign mem_req   = req & reset_n;
    assign mem_addr  = addr_full[ADDR_WIDTH-1:0];
    assign mem_wdata = b_reg;
    assign halted    = (cur_state == S_TRAP);
    assign state     = cur_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (pc_we)  pc      <= pc_next;
            if (ir_we)  ir      <= mem_rdata;
            if (ab_we) begin
                a_reg <= regs[rs];
                b_reg <= regs[rt];
            end
            if (alu_we) alu_out <= alu_next;
            if (mdr_we) mdr     <= mem_rdata;
            // r0 is never written, so its reset value of zero is what every read sees
            if (rf_we && (rf_waddr != 5'd0)) regs[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed testbench for multicycle_cpu with a word memory model that inserts
// a configurable number of wait states for fetch and data accesses.
module tb_multicycle_cpu;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] SENT     = 32'hA5A5_A5A5;
    localparam logic [5:0]  OP_J = 6'h02, OP_JAL = 6'h03, OP_BNE = 6'h05, OP_XORI = 6'h0E;
    localparam logic [5:0]  OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0]  FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2A, FN_JR = 6'h08;

    logic        clk;
    logic        reset_n;
    logic        mem_req, mem_we, retire, halted;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata, pc;
    logic [31:0] mem_rdata = 32'h0;
    logic [2:0]  state;

    logic [31:0] prog [1024];
    logic [31:0] mem  [1024];
    int fetch_waits, data_waits, wait_cnt;
    int tests_run, tests_failed;

    multicycle_cpu #(.RESET_PC(RESET_PC), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc(pc), .retire(retire), .halted(halted), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory answers on the falling edge; the program image is reloaded while reset is held
    always @(negedge clk) begin : mem_model
        int need;
        need = (state == 3'd0) ? fetch_waits : data_waits;
        if (!reset_n) begin
            mem       = prog;
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end else if (mem_req) begin
            if (wait_cnt >= need) begin
                mem_ready = 1'b1;
                wait_cnt  = 0;
                if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
                else        mem_rdata = mem[mem_addr[11:2]];
            end else begin
                mem_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) prog[i] = SENT;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic wait_retire(input int limit, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!retire && cycles < limit);
    endtask

    task automatic test_reset();
        int n;
        clear_prog();
        prog[0] = enc_i(OP_XORI, 5'd0, 5'd1, 16'd5);
        prog[1] = enc_j(OP_J, 26'd1);
        #3;
        reset_n = 1'b0;
        #1;
        tests_run++; if (pc !== RESET_PC) begin tests_failed++; $display("[TB] FAIL reset pc: got %h expected %h", pc, RESET_PC); end
        tests_run++; if (state !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset state: got %0d expected 0", state); end
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset mem_req: got %b expected 0", mem_req); end
        tests_run++; if (retire !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset retire: got %b expected 0", retire); end
        tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset halted: got %b expected 0", halted); end
        repeat (2) @(posedge clk);
        #2;
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset held mem_req: got %b expected 0", mem_req); end
        reset_n = 1'b1;
        step();
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL first fetch req: got %b expected 1", mem_req); end
        tests_run++; if (mem_addr !== RESET_PC) begin tests_failed++; $display("[TB] FAIL first fetch addr: got %h expected %h", mem_addr, RESET_PC); end
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL first fetch we: got %b expected 0", mem_we); end
        wait_retire(50, n);
        tests_run++; if (n !== 3) begin tests_failed++; $display("[TB] FAIL first xori latency: got %0d expected 3", n); end
    endtask

    task automatic test_xori_add();
        logic rb [1:8];
        int nret;
        logic [31:0] pc8;
        clear_prog();
        prog[0]  = enc_i(OP_XORI, 5'd0, 5'd1, 16'd5);
        prog[1]  = enc_r(5'd1, 5'd1, 5'd2, FN_ADD);
        prog[2]  = enc_i(OP_SW, 5'd0, 5'd2, 16'h0080);
        prog[3]  = enc_r(5'd0, 5'd1, 5'd4, FN_SUB);
        prog[4]  = enc_r(5'd4, 5'd1, 5'd5, FN_SLT);
        prog[5]  = enc_r(5'd1, 5'd4, 5'd6, FN_SLT);
        prog[6]  = enc_i(OP_XORI, 5'd0, 5'd7, 16'hFFFF);
        prog[7]  = enc_i(OP_SW, 5'd0, 5'd4, 16'h0084);
        prog[8]  = enc_i(OP_SW, 5'd0, 5'd5, 16'h0088);
        prog[9]  = enc_i(OP_SW, 5'd0, 5'd6, 16'h008C);
        prog[10] = enc_i(OP_SW, 5'd0, 5'd7, 16'h0090);
        prog[11] = enc_j(OP_J, 26'd11);
        do_reset();
        nret = 0;
        pc8  = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            step();
            rb[c] = retire;
            if (retire === 1'b1) nret++;
            if (c == 8) pc8 = pc;
        end
        tests_run++; if (rb[4] !== 1'b1) begin tests_failed++; $display("[TB] FAIL xori retire cycle4: got %b expected 1", rb[4]); end
        tests_run++; if (rb[8] !== 1'b1) begin tests_failed++; $display("[TB] FAIL add retire cycle8: got %b expected 1", rb[8]); end
        tests_run++; if (nret !== 2) begin tests_failed++; $display("[TB] FAIL retire count 1..8: got %0d expected 2", nret); end
        tests_run++; if (pc8 !== 32'h8) begin tests_failed++; $display("[TB] FAIL pc after add: got %h expected %h", pc8, 32'h8); end
        repeat (60) step();
        tests_run++; if (mem[32] !== 32'd10) begin tests_failed++; $display("[TB] FAIL add result: got %h expected %h", mem[32], 32'd10); end
        tests_run++; if (mem[33] !== 32'hFFFF_FFFB) begin tests_failed++; $display("[TB] FAIL sub wrap: got %h expected %h", mem[33], 32'hFFFF_FFFB); end
        tests_run++; if (mem[34] !== 32'd1) begin tests_failed++; $display("[TB] FAIL slt neg<pos: got %h expected 1", mem[34]); end
        tests_run++; if (mem[35] !== 32'd0) begin tests_failed++; $display("[TB] FAIL slt pos<neg: got %h expected 0", mem[35]); end
        tests_run++; if (mem[36] !== 32'h0000_FFFF) begin tests_failed++; $display("[TB] FAIL xori zext: got %h expected %h", mem[36], 32'h0000_FFFF); end
    endtask

    task automatic test_mem_wait();
        int rc [8];
        int nr;
        logic prev_req, prev_rdy, prev_we;
        logic [31:0] prev_addr, prev_wdata;
        clear_prog();
        prog[0] = enc_i(OP_XORI, 5'd0, 5'd2, 16'd10);
        prog[1] = enc_i(OP_SW, 5'd0, 5'd2, 16'h0010);
        prog[2] = enc_i(OP_LW, 5'd0, 5'd3, 16'h0010);
        prog[3] = enc_j(OP_J, 26'd6);
        prog[6] = enc_i(OP_SW, 5'd0, 5'd3, 16'h0014);
        prog[7] = enc_j(OP_J, 26'd7);
        data_waits = 3;
        do_reset();
        nr = 0;
        for (int i = 0; i < 8; i++) rc[i] = 0;
        prev_req = 1'b0; prev_rdy = 1'b0; prev_we = 1'b0;
        prev_addr = 32'h0; prev_wdata = 32'h0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (mem_req && prev_req && !prev_rdy) begin
                tests_run++;
                if (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata) begin
                    tests_failed++;
                    $display("[TB] FAIL wait stability c%0d: got %h/%b/%h expected %h/%b/%h", c, mem_addr, mem_we, mem_wdata, prev_addr, prev_we, prev_wdata);
                end
            end
            if (retire === 1'b1 && nr < 8) begin rc[nr] = c; nr++; end
            prev_req = mem_req; prev_rdy = mem_ready; prev_we = mem_we;
            prev_addr = mem_addr; prev_wdata = mem_wdata;
        end
        data_waits = 0;
        tests_run++; if (rc[0] !== 4) begin tests_failed++; $display("[TB] FAIL wait xori retire: got %0d expected 4", rc[0]); end
        tests_run++; if (rc[1] - rc[0] !== 7) begin tests_failed++; $display("[TB] FAIL sw 3-wait latency: got %0d expected 7", rc[1] - rc[0]); end
        tests_run++; if (rc[2] - rc[1] !== 8) begin tests_failed++; $display("[TB] FAIL lw 3-wait latency: got %0d expected 8", rc[2] - rc[1]); end
        tests_run++; if (mem[4] !== 32'd10) begin tests_failed++; $display("[TB] FAIL stored word: got %h expected %h", mem[4], 32'd10); end
        tests_run++; if (mem[5] !== 32'd10) begin tests_failed++; $display("[TB] FAIL lw r3 value: got %h expected %h", mem[5], 32'd10); end
    endtask

    task automatic test_bne();
        int n;
        clear_prog();
        prog[0] = enc_i(OP_XORI, 5'd0, 5'd1, 16'd5);
        prog[1] = enc_i(OP_BNE, 5'd1, 5'd0, 16'hFFFF);
        do_reset();
        wait_retire(50, n);
        wait_retire(50, n);
        tests_run++; if (n !== 3) begin tests_failed++; $display("[TB] FAIL bne latency: got %0d expected 3", n); end
        for (int k = 0; k < 3; k++) begin
            step();
            tests_run++; if (pc !== 32'h4) begin tests_failed++; $display("[TB] FAIL bne taken pc iter%0d: got %h expected %h", k, pc, 32'h4); end
            wait_retire(50, n);
            tests_run++; if (n !== 2) begin tests_failed++; $display("[TB] FAIL bne loop iter%0d: got %0d expected 2", k, n); end
        end
        clear_prog();
        prog[0] = enc_i(OP_BNE, 5'd1, 5'd0, 16'hFFFF);
        prog[1] = enc_j(OP_J, 26'd1);
        do_reset();
        wait_retire(50, n);
        tests_run++; if (n !== 3) begin tests_failed++; $display("[TB] FAIL bne not-taken latency: got %0d expected 3", n); end
        step();
        tests_run++; if (pc !== 32'h4) begin tests_failed++; $display("[TB] FAIL bne not-taken pc: got %h expected %h", pc, 32'h4); end
        wait_retire(50, n);
        step();
        tests_run++; if (pc !== 32'h4) begin tests_failed++; $display("[TB] FAIL j self pc: got %h expected %h", pc, 32'h4); end
    endtask

    task automatic test_jal_jr();
        int n;
        clear_prog();
        prog[0]   = enc_j(OP_J, 26'h10);
        prog[16]  = enc_j(OP_JAL, 26'h100);
        prog[17]  = enc_i(OP_SW, 5'd0, 5'd31, 16'h0200);
        prog[18]  = enc_j(OP_J, 26'h12);
        prog[256] = enc_r(5'd31, 5'd0, 5'd0, FN_JR);
        do_reset();
        wait_retire(50, n);
        tests_run++; if (n !== 3) begin tests_failed++; $display("[TB] FAIL j latency: got %0d expected 3", n); end
        step();
        tests_run++; if (pc !== 32'h40) begin tests_failed++; $display("[TB] FAIL j pc: got %h expected %h", pc, 32'h40); end
        wait_retire(50, n);
        step();
        tests_run++; if (pc !== 32'h400) begin tests_failed++; $display("[TB] FAIL jal pc: got %h expected %h", pc, 32'h400); end
        wait_retire(50, n);
        step();
        tests_run++; if (pc !== 32'h44) begin tests_failed++; $display("[TB] FAIL jr pc: got %h expected %h", pc, 32'h44); end
        repeat (20) step();
        tests_run++; if (mem[128] !== 32'h44) begin tests_failed++; $display("[TB] FAIL jal link r31: got %h expected %h", mem[128], 32'h44); end
    endtask

    task automatic test_trap();
        logic [31:0] exp_pc;
        logic saw_req, saw_ret;
        for (int k = 0; k < 3; k++) begin
            clear_prog();
            exp_pc = 32'h8;
            case (k)
                0: begin
                    prog[0] = enc_i(OP_XORI, 5'd0, 5'd1, 16'd5);
                    prog[1] = 32'hFC00_0000;
                end
                1: begin
                    prog[0] = enc_i(OP_XORI, 5'd0, 5'd1, 16'h0013);
                    prog[1] = enc_i(OP_LW, 5'd1, 5'd2, 16'h0000);
                end
                default: begin
                    prog[0] = enc_r(5'd0, 5'd0, 5'd0, 6'h21);
                    exp_pc  = 32'h4;
                end
            endcase
            prog[2] = enc_i(OP_SW, 5'd0, 5'd1, 16'h0080);
            do_reset();
            repeat (12) step();
            tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("[TB] FAIL trap%0d halted: got %b expected 1", k, halted); end
            tests_run++; if (state !== 3'd7) begin tests_failed++; $display("[TB] FAIL trap%0d state: got %0d expected 7", k, state); end
            saw_req = 1'b0;
            saw_ret = 1'b0;
            for (int c = 0; c < 10; c++) begin
                step();
                if (mem_req !== 1'b0) saw_req = 1'b1;
                if (retire !== 1'b0) saw_ret = 1'b1;
            end
            tests_run++; if (pc !== exp_pc) begin tests_failed++; $display("[TB] FAIL trap%0d pc: got %h expected %h", k, pc, exp_pc); end
            tests_run++; if (saw_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL trap%0d mem_req seen: got %b expected 0", k, saw_req); end
            tests_run++; if (saw_ret !== 1'b0) begin tests_failed++; $display("[TB] FAIL trap%0d retire seen: got %b expected 0", k, saw_ret); end
            tests_run++; if (mem[32] !== SENT) begin tests_failed++; $display("[TB] FAIL trap%0d memory changed: got %h expected %h", k, mem[32], SENT); end
        end
    endtask

    task automatic test_reset_mid_fetch();
        int n;
        clear_prog();
        prog[0] = enc_i(OP_XORI, 5'd0, 5'd1, 16'd7);
        prog[1] = enc_i(OP_SW, 5'd0, 5'd1, 16'h0080);
        prog[2] = enc_j(OP_J, 26'd2);
        fetch_waits = 4;
        do_reset();
        step();
        step();
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL fetch wait req: got %b expected 1", mem_req); end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid-fetch reset req: got %b expected 0", mem_req); end
        tests_run++; if (state !== 3'd0) begin tests_failed++; $display("[TB] FAIL mid-fetch reset state: got %0d expected 0", state); end
        tests_run++; if (pc !== RESET_PC) begin tests_failed++; $display("[TB] FAIL mid-fetch reset pc: got %h expected %h", pc, RESET_PC); end
        fetch_waits = 0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        step();
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL restart req: got %b expected 1", mem_req); end
        tests_run++; if (mem_addr !== RESET_PC) begin tests_failed++; $display("[TB] FAIL restart addr: got %h expected %h", mem_addr, RESET_PC); end
        wait_retire(50, n);
        tests_run++; if (n !== 3) begin tests_failed++; $display("[TB] FAIL restart xori latency: got %0d expected 3", n); end
        repeat (20) step();
        tests_run++; if (mem[32] !== 32'd7) begin tests_failed++; $display("[TB] FAIL restart program result: got %h expected %h", mem[32], 32'd7); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        fetch_waits  = 0;
        data_waits   = 0;
        reset_n      = 1'b1;
        test_reset();
        test_xori_add();
        test_mem_wait();
        test_bne();
        test_jal_jr();
        test_trap();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got still running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
